// File: rtl/uart_recv.sv
// 8N1 UART receiver: two-flop line synchronizer plus a single-FSM sampler that
// takes one mid-bit sample per bit, with a glitch reject on the start bit and break handling.
module uart_recv #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] out_dat,
  output logic       out_flag,
  output logic       frame_err,
  output logic       busy
);

  localparam int N  = CLK_FREQ / BAUD;
  localparam int H  = N / 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] FULL = CW'(N - 1);
  localparam logic [CW-1:0] HALF = CW'(H - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          rx_meta;
  logic          rxs;

  // Both flops reset high so that a reset never looks like a start bit.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      out_dat   <= '0;
      out_flag  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_flag  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= '0;
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (rxs) begin
              out_dat  <= shreg;
              out_flag <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // A held-low line is a break, not a new start bit.
        WAIT_HIGH: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv: pre-built line/reset waveform, frame-level lookahead model,
// per-cycle compare against the model plus literal pins on the directed frames.
module tb_uart_recv;

  localparam int N = 10;
  localparam int H = 5;
  localparam int T = 8000;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] out_dat;
  logic       out_flag;
  logic       frame_err;
  logic       busy;

  uart_recv #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .rxd      (rxd),
    .out_dat  (out_dat),
    .out_flag (out_flag),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Index e means "value present at / visible after rising edge number e".
  logic       rx_at   [T];
  logic       rstn_at [T];
  logic [7:0] exp_dat [T];
  logic       exp_flag[T];
  logic       exp_err [T];
  logic       exp_busy[T];

  int         wp = 0;
  int         directed_end = 0;
  int         checks = 0;
  int         failures = 0;
  int         edge_idx = -1;
  bit         running = 1'b0;
  int         flag_edges[$];
  logic [7:0] flag_bytes[$];
  int         err_edges[$];

  function automatic void push(logic v, logic r, int n);
    for (int i = 0; i < n; i++) begin
      if (wp < T) begin
        rx_at[wp]   = v;
        rstn_at[wp] = r;
        wp++;
      end
    end
  endfunction

  // Optional noise lands at bit offsets 1 or 8, well clear of the mid-bit sample.
  function automatic void send_frame(logic [7:0] b, logic stop_bit, bit noisy);
    logic [9:0] bits = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      int base = wp;
      push(bits[k], 1'b1, N);
      if (noisy && k > 0 && base + 9 < T && $urandom_range(0, 2) == 0)
        rx_at[base + (($urandom_range(0, 1) == 1) ? 1 : 8)] = ~bits[k];
    end
  endfunction

  function automatic void apply_stimulus();
    logic [7:0] b;
    push(1'b1, 1'b0, 5);
    push(1'b1, 1'b1, 20);
    send_frame(8'h55, 1'b1, 1'b0);
    push(1'b1, 1'b1, 20);
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'h82, 1'b1, 1'b0);
    push(1'b1, 1'b1, 20);
    push(1'b0, 1'b1, 3);
    push(1'b1, 1'b1, 20);
    send_frame(8'hA5, 1'b0, 1'b0);
    push(1'b0, 1'b1, 30);
    push(1'b1, 1'b1, 20);
    b = 8'h3C;
    push(1'b0, 1'b1, N);
    for (int k = 0; k < 4; k++) push(b[k], 1'b1, N);
    push(1'b1, 1'b0, 3);
    push(1'b1, 1'b1, 20);
    send_frame(8'hC3, 1'b1, 1'b0);
    push(1'b1, 1'b1, 20);
    directed_end = wp;
    for (int i = 0; i < 40; i++) begin
      int kind = $urandom_range(0, 99);
      int st;
      push(1'b1, 1'b1, $urandom_range(0, 15));
      b = 8'($urandom);
      if (kind < 65) begin
        send_frame(b, 1'b1, 1'b1);
      end else if (kind < 80) begin
        send_frame(b, 1'b0, 1'b1);
        push(1'b0, 1'b1, $urandom_range(0, 20));
        push(1'b1, 1'b1, 5);
      end else if (kind < 93) begin
        push(1'b0, 1'b1, $urandom_range(1, 4));
        push(1'b1, 1'b1, 3);
      end else begin
        st = wp;
        send_frame(b, 1'b1, 1'b0);
        wp = st + $urandom_range(15, 90);
        push(1'b1, 1'b0, 2);
      end
    end
    push(1'b1, 1'b1, T - wp);
  endfunction

  // Line value the receiver logic sees at edge e (two-edge latency, forced high by reset).
  function automatic logic rs(int e);
    if (e < 2 || e >= T) return 1'b1;
    if (!rstn_at[e-1] || !rstn_at[e-2]) return 1'b1;
    return rx_at[e-2];
  endfunction

  // Frame-level model: find a falling edge, look ahead to the fixed sample edges.
  function automatic void build_model();
    logic [7:0] dat = 8'h00;
    int e = 0;
    for (int i = 0; i < T; i++) begin
      exp_flag[i] = 1'b0; exp_err[i] = 1'b0; exp_busy[i] = 1'b0; exp_dat[i] = 8'h00;
    end
    while (e < T) begin
      if (!rstn_at[e]) begin
        dat = 8'h00; exp_dat[e] = dat; e++;
      end else if (rs(e)) begin
        exp_dat[e] = dat; e++;
      end else begin
        int d = e;
        int stop_e = e + H + 9 * N;
        int fin;
        int kind;
        int abort = -1;
        logic [7:0] byt = 8'h00;
        if (rs(d + H)) begin
          fin = d + H; kind = 0;
        end else begin
          for (int k = 0; k < 8; k++) byt[k] = rs(d + H + (k + 1) * N);
          if (rs(stop_e)) begin
            fin = stop_e; kind = 1;
          end else begin
            kind = 2; fin = stop_e + 1;
            while (fin < T && !rs(fin)) fin++;
          end
        end
        for (int x = d + 1; x <= fin && x < T; x++)
          if (!rstn_at[x]) begin abort = x; break; end
        if (abort >= 0) fin = abort;
        for (int x = d; x < fin && x < T; x++) begin
          exp_busy[x] = 1'b1; exp_dat[x] = dat;
        end
        if (kind == 2 && stop_e < fin && stop_e < T) exp_err[stop_e] = 1'b1;
        if (abort >= 0) begin
          e = abort;
        end else begin
          if (kind == 1) begin
            dat = byt;
            if (fin < T) exp_flag[fin] = 1'b1;
          end
          if (kind == 2 && stop_e == fin && stop_e < T) exp_err[stop_e] = 1'b1;
          if (fin < T) exp_dat[fin] = dat;
          e = fin + 1;
        end
      end
    end
  endfunction

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp, input int at);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s edge=%0d got=%h expected=%h", name, at, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (running && edge_idx >= 0) begin
      check_output("out_flag", {7'd0, out_flag}, {7'd0, exp_flag[edge_idx]}, edge_idx);
      check_output("frame_err", {7'd0, frame_err}, {7'd0, exp_err[edge_idx]}, edge_idx);
      check_output("busy", {7'd0, busy}, {7'd0, exp_busy[edge_idx]}, edge_idx);
      check_output("out_dat", out_dat, exp_dat[edge_idx], edge_idx);
      if (out_flag === 1'b1) begin
        flag_edges.push_back(edge_idx);
        flag_bytes.push_back(out_dat);
      end
      if (frame_err === 1'b1) err_edges.push_back(edge_idx);
    end
  end

  initial begin
    int nflag;
    int nerr;
    logic [7:0] want [4];
    apply_stimulus();
    build_model();
    rxd = rx_at[0];
    rst = rstn_at[0];
    running = 1'b1;
    for (int e = 0; e < T; e++) begin
      @(posedge sys_clk);
      edge_idx = e;
      #1;
      if (e + 1 < T) begin
        rxd = rx_at[e+1];
        rst = rstn_at[e+1];
      end
      @(negedge sys_clk);
    end
    #1;
    running = 1'b0;

    want[0] = 8'h55; want[1] = 8'h55; want[2] = 8'h82; want[3] = 8'hC3;
    nflag = 0;
    foreach (flag_edges[i]) if (flag_edges[i] < directed_end) nflag++;
    check_output("directed_flag_count", 8'(nflag), 8'd4, directed_end);
    for (int i = 0; i < 4; i++)
      check_output("directed_byte", (flag_bytes.size() > i) ? flag_bytes[i] : 8'hxx, want[i], i);
    check_output("back_to_back_gap",
                 (flag_edges.size() > 2) ? 8'(flag_edges[2] - flag_edges[1]) : 8'hxx, 8'd100, 2);
    nerr = 0;
    foreach (err_edges[i]) if (err_edges[i] < directed_end) nerr++;
    check_output("directed_err_count", 8'(nerr), 8'd1, directed_end);
    nflag = 0;
    for (int i = 0; i < directed_end; i++) if (exp_flag[i]) nflag++;
    check_output("model_flag_count", 8'(nflag), 8'd4, directed_end);
    check_output("model_last_dat", exp_dat[directed_end-1], 8'hC3, directed_end - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
